// File: rtl/alu_issue_queue.sv
// +--------------------------------------------------------------------------+
// | alu_issue_queue : DEPTH-entry FIFO issuing one op/cycle onto registered  |
// |                   ALU input buses. Option: ALU_ISSUE_DIV0_GUARD_EN       |
// | Revision        : 1.0                                                    |
// +--------------------------------------------------------------------------+
`default_nettype none

module alu_issue_queue #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_opcode,
  input  logic [DATA_W-1:0]        in_operand1,
  input  logic [DATA_W-1:0]        in_operand2,
  input  logic                     stall,
  output logic [1:0]               alu_opcode,
  output logic [DATA_W-1:0]        alu_operand1,
  output logic [DATA_W-1:0]        alu_operand2,
  output logic                     alu_issue,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     div0_err
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = 2 + 2 * DATA_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [ENTRY_W-1:0] head;
  logic               push;
  logic               pop;
  logic               drop;

  // Full blocks the push even when a pop happens on the same edge.
  assign in_ready = !rst && (count != FULL_CNT);
  assign push     = in_valid && in_ready;
  assign pop      = (count != '0) && !stall;
  assign head     = mem[rd_ptr];

`ifdef ALU_ISSUE_DIV0_GUARD_EN
  localparam logic [1:0] OP_DIV = 2'd3;
  assign drop = (head[ENTRY_W-1 -: 2] == OP_DIV) && (head[DATA_W-1:0] == '0);
`else
  assign drop = 1'b0;
`endif

  // Storage carries no reset; stale entries are unreachable once count clears.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_opcode, in_operand1, in_operand2};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      alu_opcode   <= 2'd0;
      alu_operand1 <= '0;
      alu_operand2 <= '0;
      alu_issue    <= 1'b0;
      div0_err     <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end

      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase

      alu_issue <= 1'b0;
      div0_err  <= 1'b0;
      if (pop) begin
        if (drop) begin
          div0_err <= 1'b1;
        end else begin
          alu_opcode   <= head[ENTRY_W-1 -: 2];
          alu_operand1 <= head[2*DATA_W-1 -: DATA_W];
          alu_operand2 <= head[DATA_W-1:0];
          alu_issue    <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_queue.sv
// Self-checking bench for alu_issue_queue: directed table, corner sequences,
// and randomized traffic against a queue-based reference model.
`default_nettype none

module tb_alu_issue_queue;

  localparam int DEPTH  = 8;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_opcode;
  logic [DATA_W-1:0] in_operand1;
  logic [DATA_W-1:0] in_operand2;
  logic              stall;
  logic [1:0]        alu_opcode;
  logic [DATA_W-1:0] alu_operand1;
  logic [DATA_W-1:0] alu_operand2;
  logic              alu_issue;
  logic [3:0]        count;
  logic              div0_err;

  always #5 clk = ~clk;

  alu_issue_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_opcode    (in_opcode),
    .in_operand1  (in_operand1),
    .in_operand2  (in_operand2),
    .stall        (stall),
    .alu_opcode   (alu_opcode),
    .alu_operand1 (alu_operand1),
    .alu_operand2 (alu_operand2),
    .alu_issue    (alu_issue),
    .count        (count),
    .div0_err     (div0_err)
  );

  typedef struct {
    logic [1:0]        op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } entry_t;

  typedef struct {
    logic              r;
    logic              v;
    logic [1:0]        op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              s;
    logic [3:0]        e_cnt;
    logic              e_iss;
    logic [1:0]        e_op;
    logic [DATA_W-1:0] e_a;
    logic [DATA_W-1:0] e_b;
  } vec_t;

  // Reference model: a plain queue plus the last-issued operation.
  entry_t            q[$];
  logic [1:0]        m_op;
  logic [DATA_W-1:0] m_a;
  logic [DATA_W-1:0] m_b;
  logic              m_issue;
  logic              m_div0;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [1:0] op,
                      input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                      input logic s);
    bit     ready;
    bit     do_pop;
    bit     do_push;
    entry_t e;
    @(negedge clk);
    rst = r; in_valid = v; in_opcode = op; in_operand1 = a; in_operand2 = b; stall = s;
    #1;
    ready = !r && (q.size() != DEPTH);
    chk("in_ready", {31'd0, in_ready}, {31'd0, ready});
    @(posedge clk);
    if (r) begin
      q.delete();
      m_op = 2'd0; m_a = '0; m_b = '0; m_issue = 1'b0; m_div0 = 1'b0;
    end else begin
      do_pop  = (q.size() != 0) && !s;
      do_push = v && ready;
      m_issue = 1'b0;
      m_div0  = 1'b0;
      if (do_pop) begin
        e = q.pop_front();
`ifdef ALU_ISSUE_DIV0_GUARD_EN
        if (e.op == 2'd3 && e.b == '0) m_div0 = 1'b1; else
`endif
        begin
          m_op = e.op; m_a = e.a; m_b = e.b; m_issue = 1'b1;
        end
      end
      if (do_push) q.push_back('{op: op, a: a, b: b});
    end
    #1;
    chk("count",        {28'd0, count},        q.size());
    chk("alu_opcode",   {30'd0, alu_opcode},   {30'd0, m_op});
    chk("alu_operand1", {24'd0, alu_operand1}, {24'd0, m_a});
    chk("alu_operand2", {24'd0, alu_operand2}, {24'd0, m_b});
    chk("alu_issue",    {31'd0, alu_issue},    {31'd0, m_issue});
    chk("div0_err",     {31'd0, div0_err},     {31'd0, m_div0});
  endtask

  task automatic idle(input logic s);
    step(1'b0, 1'b0, 2'd0, '0, '0, s);
  endtask

  task automatic push_op(input logic [1:0] op, input logic [DATA_W-1:0] a,
                         input logic [DATA_W-1:0] b, input logic s);
    step(1'b0, 1'b1, op, a, b, s);
  endtask

  vec_t tbl[9];

  initial begin
    logic [1:0]        r_op;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [1:0]        prev_op;
    logic [DATA_W-1:0] prev_a;
    logic [DATA_W-1:0] prev_b;

    rst = 1'b1; in_valid = 1'b0; in_opcode = 2'd0;
    in_operand1 = '0; in_operand2 = '0; stall = 1'b0;

    //        r     v     op    a      b      s    | cnt   iss   op    a      b
    tbl[0] = '{1'b1, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 4'd0, 1'b0, 2'd0, 8'h00, 8'h00};
    tbl[1] = '{1'b0, 1'b1, 2'd0, 8'h05, 8'h03, 1'b0, 4'd1, 1'b0, 2'd0, 8'h00, 8'h00};
    tbl[2] = '{1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 4'd0, 1'b1, 2'd0, 8'h05, 8'h03};
    tbl[3] = '{1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 4'd0, 1'b0, 2'd0, 8'h05, 8'h03};
    tbl[4] = '{1'b0, 1'b1, 2'd1, 8'h80, 8'h01, 1'b0, 4'd1, 1'b0, 2'd0, 8'h05, 8'h03};
    tbl[5] = '{1'b0, 1'b1, 2'd2, 8'h10, 8'h10, 1'b0, 4'd1, 1'b1, 2'd1, 8'h80, 8'h01};
    tbl[6] = '{1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 4'd1, 1'b0, 2'd1, 8'h80, 8'h01};
    tbl[7] = '{1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 4'd0, 1'b1, 2'd2, 8'h10, 8'h10};
    tbl[8] = '{1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 4'd0, 1'b0, 2'd2, 8'h10, 8'h10};

    for (int i = 0; i < 9; i++) begin
      step(tbl[i].r, tbl[i].v, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].s);
      chk("tbl_count", {28'd0, count},        {28'd0, tbl[i].e_cnt});
      chk("tbl_issue", {31'd0, alu_issue},    {31'd0, tbl[i].e_iss});
      chk("tbl_op",    {30'd0, alu_opcode},   {30'd0, tbl[i].e_op});
      chk("tbl_a",     {24'd0, alu_operand1}, {24'd0, tbl[i].e_a});
      chk("tbl_b",     {24'd0, alu_operand2}, {24'd0, tbl[i].e_b});
    end

    // Reset with three queued entries and an issue in flight.
    push_op(2'd0, 8'h11, 8'h22, 1'b1);
    push_op(2'd1, 8'h33, 8'h44, 1'b1);
    push_op(2'd2, 8'h55, 8'h66, 1'b1);
    push_op(2'd3, 8'h01, 8'h02, 1'b0);
    step(1'b1, 1'b1, 2'd1, 8'h77, 8'h01, 1'b0);
    idle(1'b0);
    chk("rst_count", {28'd0, count},     32'd0);
    chk("rst_op1",   {24'd0, alu_operand1}, 32'd0);
    chk("rst_issue", {31'd0, alu_issue}, 32'd0);
    chk("rst_ready", {31'd0, in_ready},  32'd1);

    // Fill under stall, refuse the ninth push, then drain in order.
    push_op(2'd1, 8'h80, 8'h01, 1'b1);
    push_op(2'd2, 8'h10, 8'h10, 1'b1);
    for (int i = 0; i < 6; i++) push_op(2'($urandom), 8'($urandom), 8'($urandom_range(1, 255)), 1'b1);
    push_op(2'd0, 8'h2A, 8'h01, 1'b1);
    chk("full_count", {28'd0, count},    32'd8);
    chk("full_ready", {31'd0, in_ready}, 32'd0);
    push_op(2'd0, 8'h2A, 8'h01, 1'b0);
    chk("drain_first_op", {30'd0, alu_opcode},   32'd1);
    chk("drain_first_a",  {24'd0, alu_operand1}, 32'h80);
    chk("drain_ready",    {31'd0, in_ready},     32'd1);
    for (int i = 0; i < 7; i++) begin
      idle(1'b0);
      chk("drain_issue", {31'd0, alu_issue}, 32'd1);
    end
    idle(1'b0);

    // Steady state at occupancy four with push and pop every cycle.
    for (int i = 0; i < 4; i++) push_op(2'($urandom), 8'($urandom), 8'($urandom_range(1, 255)), 1'b1);
    for (int i = 0; i < 20; i++) begin
      push_op(2'($urandom), 8'($urandom), 8'($urandom_range(1, 255)), 1'b0);
      chk("steady_count", {28'd0, count},     32'd4);
      chk("steady_issue", {31'd0, alu_issue}, 32'd1);
    end
    for (int i = 0; i < 5; i++) idle(1'b0);

    // Divide-by-zero followed by ADD(1,2).
    prev_op = alu_opcode; prev_a = alu_operand1; prev_b = alu_operand2;
    push_op(2'd3, 8'h07, 8'h00, 1'b0);
    push_op(2'd0, 8'h01, 8'h02, 1'b0);
`ifdef ALU_ISSUE_DIV0_GUARD_EN
    chk("div0_err_pulse", {31'd0, div0_err},     32'd1);
    chk("div0_no_issue",  {31'd0, alu_issue},    32'd0);
    chk("div0_hold_op",   {30'd0, alu_opcode},   {30'd0, prev_op});
    chk("div0_hold_a",    {24'd0, alu_operand1}, {24'd0, prev_a});
    chk("div0_hold_b",    {24'd0, alu_operand2}, {24'd0, prev_b});
`else
    chk("div_issue",    {31'd0, alu_issue},    32'd1);
    chk("div_opcode",   {30'd0, alu_opcode},   32'd3);
    chk("div_operand2", {24'd0, alu_operand2}, 32'd0);
    chk("div_no_err",   {31'd0, div0_err},     32'd0);
`endif
    idle(1'b0);
    chk("add_after_div_op", {30'd0, alu_opcode},   32'd0);
    chk("add_after_div_a",  {24'd0, alu_operand1}, 32'd1);
    chk("add_after_div_b",  {24'd0, alu_operand2}, 32'd2);
    chk("add_after_div_i",  {31'd0, alu_issue},    32'd1);

    // Randomized traffic with occasional resets and zero divisors.
    for (int i = 0; i < 400; i++) begin
      r_op = 2'($urandom);
      r_a  = 8'($urandom);
      r_b  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      step(($urandom_range(0, 60) == 0), ($urandom_range(0, 3) != 0),
           r_op, r_a, r_b, ($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
